// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, parity codes, default link settings
// and the clocks-per-bit derivation used by both the transmitter and receiver.
package uart_pkg;

    localparam int DEFAULT_CLK_FREQ = 50_000_000;
    localparam int DEFAULT_BAUDRATE = 115_200;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_ODD  = 2'd1;
    localparam logic [1:0] PARITY_EVEN = 2'd2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    function automatic int calc_cpb(input int clk_freq, input int baudrate);
        return clk_freq / baudrate;
    endfunction

    // Parity bit for a byte; code 3 falls through to "no parity" (bit unused).
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] ptype);
        logic result;
        case (ptype)
            PARITY_ODD:  result = ~^data;
            PARITY_EVEN: result = ^data;
            default:     result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CPB-1, ticks bit_end on the last cycle of a bit
// and bit_pre_end one cycle earlier so callers can register end-of-bit outputs.
module uart_baud_counter #(
    parameter int CPB = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_end,
    output logic bit_pre_end
);

    localparam int CW = (CPB > 1) ? $clog2(CPB) : 1;

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (restart || bit_end) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign bit_end     = (count_reg == CW'(CPB - 1));
    assign bit_pre_end = (count_reg == CW'(CPB - 2));

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 8 data bits LSB first, optional odd/even parity,
// one stop bit. All outputs are registered; frame settings latch at acceptance.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
    parameter int BAUDRATE = DEFAULT_BAUDRATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic [1:0] parity_type,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       serial_data_out
);

    localparam int CPB = calc_cpb(CLK_FREQ, BAUDRATE);

    tx_state_t  state_reg, state_next;
    logic [7:0] shift_reg, shift_next;
    logic [2:0] idx_reg, idx_next;
    logic [1:0] ptype_reg, ptype_next;
    logic       parity_reg, parity_next;
    logic       serial_reg, serial_next;
    logic       ready_reg, ready_next;
    logic       done_reg, done_next;
    logic       bit_end, bit_pre_end, baud_restart;

    // Holding the timer at zero while idle aligns bit periods to the start edge.
    assign baud_restart = (state_reg == TX_IDLE);

    uart_baud_counter #(
        .CPB(CPB)
    ) u_baud (
        .clk        (clk),
        .rst        (rst),
        .restart    (baud_restart),
        .bit_end    (bit_end),
        .bit_pre_end(bit_pre_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= TX_IDLE;
            shift_reg  <= '0;
            idx_reg    <= '0;
            ptype_reg  <= PARITY_NONE;
            parity_reg <= 1'b0;
            serial_reg <= 1'b1;
            ready_reg  <= 1'b1;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            shift_reg  <= shift_next;
            idx_reg    <= idx_next;
            ptype_reg  <= ptype_next;
            parity_reg <= parity_next;
            serial_reg <= serial_next;
            ready_reg  <= ready_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        shift_next  = shift_reg;
        idx_next    = idx_reg;
        ptype_next  = ptype_reg;
        parity_next = parity_reg;
        case (state_reg)
            TX_IDLE: begin
                if (tx_valid && ready_reg) begin
                    shift_next  = tx_data;
                    ptype_next  = parity_type;
                    parity_next = parity_bit(tx_data, parity_type);
                    idx_next    = '0;
                    state_next  = TX_START;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    idx_next   = '0;
                    state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    shift_next = {1'b0, shift_reg[7:1]};
                    idx_next   = idx_reg + 3'd1;
                    if (idx_reg == 3'd7) begin
                        state_next = (ptype_reg == PARITY_ODD || ptype_reg == PARITY_EVEN)
                                     ? TX_PARITY : TX_STOP;
                    end
                end
            end
            TX_PARITY: begin
                if (bit_end) begin
                    state_next = TX_STOP;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    state_next = TX_IDLE;
                end
            end
            default: state_next = TX_IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state so the registers change on the same edge.
    always_comb begin
        serial_next = 1'b1;
        case (state_next)
            TX_START:  serial_next = 1'b0;
            TX_DATA:   serial_next = shift_next[0];
            TX_PARITY: serial_next = parity_reg;
            default:   serial_next = 1'b1;
        endcase
        ready_next = (state_next == TX_IDLE);
        done_next  = (state_reg == TX_STOP) && bit_pre_end;
    end

    assign serial_data_out = serial_reg;
    assign tx_ready        = ready_reg;
    assign tx_done         = done_reg;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at default 50 MHz / 115200 baud (434 clocks per bit).
module tb_uart_transmitter;
    import uart_pkg::*;

    localparam int CPB = 434;

    logic       clk;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic [1:0] parity_type;
    logic       tx_ready;
    logic       tx_done;
    logic       serial_data_out;

    int n_cmp  = 0;
    int n_fail = 0;

    uart_transmitter dut (
        .clk            (clk),
        .rst            (rst),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .parity_type    (parity_type),
        .tx_ready       (tx_ready),
        .tx_done        (tx_done),
        .serial_data_out(serial_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    // Called at a negedge: request one byte; returns at the negedge of the first start-bit cycle.
    task automatic start_frame(input logic [7:0] d, input logic [1:0] p, input logic hold);
        tx_data     = d;
        parity_type = p;
        tx_valid    = 1'b1;
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
    endtask

    // Samples nbits*CPB+1 cycles from the current negedge; index nbits*CPB is the cycle after the frame.
    task automatic measure_frame(input int nbits, output logic [10:0] slots, output logic stable,
                                 output int done_idx, output int done_cnt, output int ready_idx,
                                 output logic ready0, output logic idle_line);
        int total;
        total     = nbits * CPB;
        slots     = '0;
        stable    = 1'b1;
        done_idx  = -1;
        done_cnt  = 0;
        ready_idx = -1;
        ready0    = tx_ready;
        idle_line = 1'bx;
        for (int i = 0; i <= total; i++) begin
            if (i < total) begin
                if (i % CPB == 0) slots[i / CPB] = serial_data_out;
                else if (serial_data_out !== slots[i / CPB]) stable = 1'b0;
            end else begin
                idle_line = serial_data_out;
            end
            if (tx_done === 1'b1) begin
                done_cnt++;
                if (done_idx < 0) done_idx = i;
            end
            if (i > 0 && ready_idx < 0 && tx_ready === 1'b1) ready_idx = i;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; parity_type = PARITY_NONE;
        repeat (3) @(negedge clk);
        n_cmp++; if (serial_data_out !== 1'b1) begin n_fail++; $display("FAIL rst_line: got %b expected 1", serial_data_out); end
        n_cmp++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", tx_ready); end
        n_cmp++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", tx_done); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (serial_data_out !== 1'b1) begin n_fail++; $display("FAIL idle_line: got %b expected 1", serial_data_out); end
        n_cmp++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b expected 1", tx_ready); end
        $display("reset: line=%b ready=%b done=%b", serial_data_out, tx_ready, tx_done);
    endtask

    task automatic test_no_parity();
        logic [10:0] slots; logic stable, ready0, idle_line; int done_idx, done_cnt, ready_idx;
        start_frame(8'h55, PARITY_NONE, 1'b0);
        measure_frame(10, slots, stable, done_idx, done_cnt, ready_idx, ready0, idle_line);
        n_cmp++; if (slots !== {1'b0, 1'b1, 8'h55, 1'b0}) begin n_fail++; $display("FAIL np_bits: got %h expected %h", slots, {1'b0, 1'b1, 8'h55, 1'b0}); end
        n_cmp++; if (stable !== 1'b1) begin n_fail++; $display("FAIL np_bit_width: got %b expected 1", stable); end
        n_cmp++; if (done_idx != 10*CPB-1) begin n_fail++; $display("FAIL np_done_time: got %0d expected %0d", done_idx, 10*CPB-1); end
        n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL np_done_count: got %0d expected 1", done_cnt); end
        n_cmp++; if (ready0 !== 1'b0) begin n_fail++; $display("FAIL np_ready_fall: got %b expected 0", ready0); end
        n_cmp++; if (ready_idx != 10*CPB) begin n_fail++; $display("FAIL np_ready_rise: got %0d expected %0d", ready_idx, 10*CPB); end
        n_cmp++; if (idle_line !== 1'b1) begin n_fail++; $display("FAIL np_idle: got %b expected 1", idle_line); end
        $display("frame 0x55 none: bits=%h done@%0d ready@%0d", slots, done_idx, ready_idx);
    endtask

    task automatic test_parity(input logic [1:0] p, input logic [10:0] exp_slots);
        logic [10:0] slots; logic stable, ready0, idle_line; int done_idx, done_cnt, ready_idx;
        start_frame(8'h07, p, 1'b0);
        tx_data = 8'hFF; parity_type = PARITY_NONE;  // mid-frame changes must not leak in
        measure_frame(11, slots, stable, done_idx, done_cnt, ready_idx, ready0, idle_line);
        n_cmp++; if (slots !== exp_slots) begin n_fail++; $display("FAIL par%0d_bits: got %h expected %h", p, slots, exp_slots); end
        n_cmp++; if (stable !== 1'b1) begin n_fail++; $display("FAIL par%0d_bit_width: got %b expected 1", p, stable); end
        n_cmp++; if (done_idx != 11*CPB-1) begin n_fail++; $display("FAIL par%0d_done_time: got %0d expected %0d", p, done_idx, 11*CPB-1); end
        n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL par%0d_done_count: got %0d expected 1", p, done_cnt); end
        n_cmp++; if (ready_idx != 11*CPB) begin n_fail++; $display("FAIL par%0d_ready_rise: got %0d expected %0d", p, ready_idx, 11*CPB); end
        $display("frame 0x07 parity=%0d: bits=%h done@%0d", p, slots, done_idx);
    endtask

    task automatic test_parity_reserved();
        logic [10:0] slots; logic stable, ready0, idle_line; int done_idx, done_cnt, ready_idx;
        start_frame(8'hA3, 2'd3, 1'b0);
        measure_frame(10, slots, stable, done_idx, done_cnt, ready_idx, ready0, idle_line);
        n_cmp++; if (slots !== {1'b0, 1'b1, 8'hA3, 1'b0}) begin n_fail++; $display("FAIL p3_bits: got %h expected %h", slots, {1'b0, 1'b1, 8'hA3, 1'b0}); end
        n_cmp++; if (stable !== 1'b1) begin n_fail++; $display("FAIL p3_bit_width: got %b expected 1", stable); end
        n_cmp++; if (done_idx != 10*CPB-1) begin n_fail++; $display("FAIL p3_done_time: got %0d expected %0d", done_idx, 10*CPB-1); end
        n_cmp++; if (ready_idx != 10*CPB) begin n_fail++; $display("FAIL p3_ready_rise: got %0d expected %0d", ready_idx, 10*CPB); end
        $display("frame 0xA3 parity=3: bits=%h done@%0d", slots, done_idx);
    endtask

    task automatic test_back_to_back();
        logic [10:0] slots1, slots2; logic stable1, stable2, r0a, r0b, idle1, idle2;
        int di1, dc1, ri1, di2, dc2, ri2;
        start_frame(8'h01, PARITY_NONE, 1'b1);
        tx_data = 8'h80;
        measure_frame(10, slots1, stable1, di1, dc1, ri1, r0a, idle1);
        fork
            measure_frame(10, slots2, stable2, di2, dc2, ri2, r0b, idle2);
            begin repeat (100) @(negedge clk); tx_valid = 1'b0; end
        join
        n_cmp++; if (slots1 !== {1'b0, 1'b1, 8'h01, 1'b0}) begin n_fail++; $display("FAIL b2b_bits1: got %h expected %h", slots1, {1'b0, 1'b1, 8'h01, 1'b0}); end
        n_cmp++; if (stable1 !== 1'b1) begin n_fail++; $display("FAIL b2b_width1: got %b expected 1", stable1); end
        n_cmp++; if (dc1 != 1) begin n_fail++; $display("FAIL b2b_done1: got %0d expected 1", dc1); end
        n_cmp++; if (idle1 !== 1'b1) begin n_fail++; $display("FAIL b2b_gap: got %b expected 1", idle1); end
        n_cmp++; if (slots2 !== {1'b0, 1'b1, 8'h80, 1'b0}) begin n_fail++; $display("FAIL b2b_bits2: got %h expected %h", slots2, {1'b0, 1'b1, 8'h80, 1'b0}); end
        n_cmp++; if (stable2 !== 1'b1) begin n_fail++; $display("FAIL b2b_width2: got %b expected 1", stable2); end
        n_cmp++; if (di2 != 10*CPB-1) begin n_fail++; $display("FAIL b2b_done2_time: got %0d expected %0d", di2, 10*CPB-1); end
        n_cmp++; if (idle2 !== 1'b1) begin n_fail++; $display("FAIL b2b_end_idle: got %b expected 1", idle2); end
        $display("back-to-back: frame1=%h frame2=%h gap_line=%b", slots1, slots2, idle1);
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] slots; logic stable, ready0, idle_line; int done_idx, done_cnt, ready_idx;
        int done_seen = 0;
        int line_low  = 0;
        start_frame(8'hC6, PARITY_NONE, 1'b0);
        for (int i = 0; i < 4*CPB + 100; i++) begin
            if (tx_done === 1'b1) done_seen++;
            @(negedge clk);
        end
        n_cmp++; if (serial_data_out !== 1'b0) begin n_fail++; $display("FAIL rmf_bit3: got %b expected 0", serial_data_out); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (serial_data_out !== 1'b1) begin n_fail++; $display("FAIL rmf_line: got %b expected 1", serial_data_out); end
        n_cmp++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rmf_ready: got %b expected 1", tx_ready); end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (tx_done === 1'b1) done_seen++;
            @(negedge clk);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (tx_done === 1'b1) done_seen++;
            if (serial_data_out !== 1'b1) line_low++;
            @(negedge clk);
        end
        n_cmp++; if (done_seen != 0) begin n_fail++; $display("FAIL rmf_no_done: got %0d expected 0", done_seen); end
        n_cmp++; if (line_low != 0) begin n_fail++; $display("FAIL rmf_idle_after: got %0d expected 0", line_low); end
        start_frame(8'h3C, PARITY_EVEN, 1'b0);
        measure_frame(11, slots, stable, done_idx, done_cnt, ready_idx, ready0, idle_line);
        n_cmp++; if (slots !== {1'b1, 1'b0, 8'h3C, 1'b0}) begin n_fail++; $display("FAIL rmf_new_bits: got %h expected %h", slots, {1'b1, 1'b0, 8'h3C, 1'b0}); end
        n_cmp++; if (stable !== 1'b1) begin n_fail++; $display("FAIL rmf_new_width: got %b expected 1", stable); end
        n_cmp++; if (done_idx != 11*CPB-1) begin n_fail++; $display("FAIL rmf_new_done: got %0d expected %0d", done_idx, 11*CPB-1); end
        $display("reset mid-frame: done_pulses=%0d new frame=%h", done_seen, slots);
    endtask

    task automatic test_busy_ignored();
        logic [10:0] slots; logic stable, ready0, idle_line; int done_idx, done_cnt, ready_idx;
        int high_cnt = 0;
        int extra_done = 0;
        start_frame(8'h96, PARITY_NONE, 1'b0);
        fork
            measure_frame(10, slots, stable, done_idx, done_cnt, ready_idx, ready0, idle_line);
            begin
                repeat (2000) @(negedge clk);
                tx_data = 8'h00; tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        for (int i = 0; i < 20; i++) begin
            if (serial_data_out === 1'b1) high_cnt++;
            if (tx_done === 1'b1) extra_done++;
            @(negedge clk);
        end
        n_cmp++; if (slots !== {1'b0, 1'b1, 8'h96, 1'b0}) begin n_fail++; $display("FAIL busy_bits: got %h expected %h", slots, {1'b0, 1'b1, 8'h96, 1'b0}); end
        n_cmp++; if (stable !== 1'b1) begin n_fail++; $display("FAIL busy_width: got %b expected 1", stable); end
        n_cmp++; if (done_cnt + extra_done != 1) begin n_fail++; $display("FAIL busy_done_count: got %0d expected 1", done_cnt + extra_done); end
        n_cmp++; if (high_cnt != 20) begin n_fail++; $display("FAIL busy_no_queue: got %0d expected 20", high_cnt); end
        $display("busy pulse ignored: frame=%h done_pulses=%0d idle_high=%0d", slots, done_cnt + extra_done, high_cnt);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_no_parity();
        test_parity(PARITY_ODD,  {1'b1, 1'b0, 8'h07, 1'b0});
        test_parity(PARITY_EVEN, {1'b1, 1'b1, 8'h07, 1'b0});
        test_parity_reserved();
        test_back_to_back();
        test_reset_mid_frame();
        test_busy_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
